noc_interface: RTL and testbench
================================

# noc_interface

Parametrised CPU-to-NoC network interface: the successor to the fixed 32/64-bit CPU/router buffer pair. It sits between one RV32IM core's memory-mapped I/O port and its router port. It holds a TX FIFO of {destination, payload} flits from the CPU and an RX FIFO of flits from the router, and adds valid/ready handshakes toward the router. It also provides a status register, sticky error flags and a threshold interrupt.

## Interface
- DATA_W, 32, width of CPU data, address and each flit half; a flit is 2*DATA_W bits, {index, data}
- DEPTH, 16, entries per FIFO; power of two, 2..128
- CTRL_ADDR, 32'hFFFF_FFFC, CPU address of the control register
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  reset, synchronous and active-low
- addr_cpu  in  DATA_W  CPU address
- data_out_cpu  in  DATA_W  CPU write data
- data_in_cpu  out  DATA_W  CPU read data, combinational
- read_en_cpu / write_en_cpu  in  1  CPU access strobes, one cycle each
- tx_valid  out  1  TX FIFO non-empty
- tx_data  out  2*DATA_W  TX head flit, {addr, data}
- tx_ready  in  1  router accepts the TX head
- rx_valid  in  1  router offers a flit
- rx_data  in  2*DATA_W  offered flit, {index, data}
- rx_ready  out  1  equals !rx_full
- irq  out  1  RX occupancy threshold interrupt

## Operation
- **FIFO storage**
  - Each FIFO is circular, with read/write pointers of log2(DEPTH) bits that wrap.
  - Each FIFO keeps a count of log2(DEPTH)+1 bits.
  - full = (count == DEPTH); empty = (count == 0).
- **CPU writes**
  - write_en_cpu with addr_cpu == CTRL_ADDR writes the control register:
    - bit 0 (write-1) clears all sticky flags.
    - bits [15:8] set the IRQ threshold.
  - Any other write pushes {addr_cpu, data_out_cpu} into TX.
  - If TX is full and no TX pop happens that cycle, the flit is dropped and tx_ovf is set (sticky).
  - If TX is full and a pop happens that same cycle, the push is accepted and the count stays at DEPTH.
- **CPU reads** (combinational data_in_cpu)
  - addr 0:
    - Returns the RX head index and pops RX on the edge.
    - The head data is latched into data_reg on the same edge.
    - If RX is empty: returns 0, no pop, data_reg unchanged, rx_udf set.
  - addr 1: returns data_reg, with no side effects.
  - addr 2: returns status:
    - [0] rx_empty, [1] rx_full, [2] tx_empty, [3] tx_full
    - [4] rx_ovf, [5] tx_ovf, [6] rx_udf
    - [15:8] rx_count, [23:16] tx_count; all other bits 0
  - CTRL_ADDR: returns the control register, {16'b0, thr, 8'b0}.
  - Any other address: returns 0.
  - When read_en_cpu is low, data_in_cpu = 0.
- **Router TX**
  - tx_data presents the TX head whenever tx_valid is high.
  - The FIFO pops on a cycle where tx_valid && tx_ready.
  - tx_data must stay stable until that pop.
- **Router RX**
  - A flit is pushed on rx_valid && rx_ready.
  - rx_valid arriving while full is ignored and sets rx_ovf (sticky).
  - A simultaneous RX push and CPU pop when RX is non-full updates both pointers; the count is unchanged.
- **Interrupt**: irq = (thr != 0) && (rx_count >= thr), derived from registered state only.
- **Sticky-flag precedence**: if a sticky-clear write and a new error occur in the same cycle, the new error wins and the flag is set.

## Timing
- **Reset** (rst_n low at an edge):
  - Pointers and counts go to 0; data_reg = 0; thr = 0; sticky flags = 0.
  - Outputs after reset: tx_valid=0, tx_data=0 (masked while empty), rx_ready=1, irq=0, data_in_cpu=0.
- Reset asserted mid-transfer discards all FIFO contents. Handshakes in that cycle are not completed.
- **Write-to-router latency**: a CPU push at edge N gives tx_valid=1 after edge N, so the earliest router pop is at edge N+1.
- **RX-to-CPU latency**: an RX push at edge N is visible to an addr 0 read in cycle N+1.
- A data_reg value latched at edge N is readable at addr 1 from cycle N+1.
- Status, count and irq values reflect registered state, i.e. they are updated one edge after the causing event.
- Throughput: one TX push and one TX pop per cycle, and likewise one RX push and one RX pop per cycle.

## Test plan
- **Reset values**: hold rst_n=0 for 2 cycles.
  - Read addr 2: 32'h0000_0005.
  - Expect tx_valid=0, rx_ready=1, irq=0.
- **TX loopback**: write addr 5, data 0xAB with tx_ready=0.
  - Next cycle: tx_valid=1, tx_data={32'd5, 32'hAB}.
  - Raise tx_ready for one cycle: tx_valid=0, tx_count=0.
- **RX pop sequence**: drive rx_data={7, 0x1234}.
  - Read addr 0 returns 7.
  - Read addr 1 returns 0x1234.
  - Status then shows rx_empty=1.
- **TX overflow with DEPTH=16, tx_ready=0**: do 17 writes.
  - tx_count=16; tx_ovf=1; the 17th flit is absent.
  - A write-1 to bit 0 of CTRL_ADDR clears tx_ovf.
  - Also write 16 flits, then a 17th in the same cycle as a pop: accepted, tx_count stays 16, and the drained order ends with the 17th flit.
- **RX full and underflow**:
  - Fill RX with 16 flits: rx_ready=0.
  - Offer a 17th flit: rx_ovf=1.
  - Drain 16 via addr 0 in FIFO order, checking pointer wrap on a second fill.
  - A 17th read returns 0 and sets rx_udf=1.
- **Interrupt**: write thr=3.
  - Push 2 flits: irq=0.
  - Push a 3rd: irq=1 one edge later.
  - One addr 0 read: irq=0.
  - Pulse rst_n mid-stream: all state is cleared.

Source files
------------

// File: rtl/noc_interface.sv
// rtl/noc_interface.sv - CPU-to-NoC network interface with TX/RX flit FIFOs
//
// noc_if_fifo: circular flit FIFO with occupancy count
//    clk, rst_n      clock, synchronous active-low reset
//    push, wdata     write request and flit
//    pop             read request (ignored while empty)
//    head            flit at the read pointer
//    count           occupancy, 0..DEPTH
//    full, empty     occupancy flags
//
// noc_interface: CPU MMIO port <-> router port
//    clk, rst_n                  clock, synchronous active-low reset
//    addr_cpu, data_out_cpu      CPU address and write data
//    write_en_cpu, read_en_cpu   single-cycle CPU access strobes
//    data_in_cpu                 CPU read data (combinational)
//    tx_valid, tx_data, tx_ready router-bound flit handshake
//    rx_valid, rx_data, rx_ready router-sourced flit handshake
//    irq                         RX occupancy threshold interrupt

module noc_if_fifo #(
   parameter int W     = 64,
   parameter int DEPTH = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  logic                       pop,
   input  logic [W-1:0]               wdata,
   output logic [W-1:0]               head,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       full,
   output logic                       empty
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic          do_pop;
   logic          do_push;

   assign full  = (count == FULL_CNT);
   assign empty = (count == '0);
   assign head  = mem[rd_ptr];

   // A push into a full FIFO is still taken when the head leaves in the
   // same cycle, so the slot being freed is reused immediately.
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n && do_push) mem[wr_ptr] <= wdata;
   end
endmodule

module noc_interface #(
   parameter int                DATA_W    = 32,
   parameter int                DEPTH     = 16,
   parameter logic [DATA_W-1:0] CTRL_ADDR = 32'hFFFF_FFFC
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DATA_W-1:0]     addr_cpu,
   input  logic [DATA_W-1:0]     data_out_cpu,
   output logic [DATA_W-1:0]     data_in_cpu,
   input  logic                  read_en_cpu,
   input  logic                  write_en_cpu,
   output logic                  tx_valid,
   output logic [2*DATA_W-1:0]   tx_data,
   input  logic                  tx_ready,
   input  logic                  rx_valid,
   input  logic [2*DATA_W-1:0]   rx_data,
   output logic                  rx_ready,
   output logic                  irq
);
   localparam int FW = 2 * DATA_W;
   localparam int CW = $clog2(DEPTH) + 1;

   logic [FW-1:0]     tx_head;
   logic [FW-1:0]     rx_head;
   logic [CW-1:0]     tx_count;
   logic [CW-1:0]     rx_count;
   logic              tx_full, tx_empty, rx_full, rx_empty;
   logic              tx_push, tx_pop, rx_push, rx_pop;

   logic [7:0]        thr;
   logic              rx_ovf, tx_ovf, rx_udf;
   logic [DATA_W-1:0] data_reg;

   logic              is_ctrl;
   logic              ctrl_wr;
   logic              flag_clr;
   logic              rd_head;
   logic              tx_ovf_evt, rx_ovf_evt, rx_udf_evt;
   logic [31:0]       status;
   logic [31:0]       ctrl_val;

   assign is_ctrl  = (addr_cpu == CTRL_ADDR);
   assign ctrl_wr  = write_en_cpu && is_ctrl;
   assign flag_clr = ctrl_wr && data_out_cpu[0];
   assign rd_head  = read_en_cpu && (addr_cpu == DATA_W'(0));

   assign tx_push = write_en_cpu && !is_ctrl;
   assign tx_pop  = tx_valid && tx_ready;
   assign rx_push = rx_valid && rx_ready;
   assign rx_pop  = rd_head && !rx_empty;

   assign tx_ovf_evt = tx_push && tx_full && !tx_pop;
   assign rx_ovf_evt = rx_valid && rx_full;
   assign rx_udf_evt = rd_head && rx_empty;

   noc_if_fifo #(.W(FW), .DEPTH(DEPTH)) u_tx_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  ({tx_push}),
      .pop   (tx_pop),
      .wdata ({addr_cpu, data_out_cpu}),
      .head  (tx_head),
      .count (tx_count),
      .full  (tx_full),
      .empty (tx_empty)
   );

   noc_if_fifo #(.W(FW), .DEPTH(DEPTH)) u_rx_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (rx_push),
      .pop   (rx_pop),
      .wdata (rx_data),
      .head  (rx_head),
      .count (rx_count),
      .full  (rx_full),
      .empty (rx_empty)
   );

   assign tx_valid = !tx_empty;
   // Head storage is not reset, so the flit is masked while nothing is queued.
   assign tx_data  = tx_empty ? '0 : tx_head;
   assign rx_ready = !rx_full;
   assign irq      = (thr != 8'd0) && (8'(rx_count) >= thr);

   // Setting an error outranks a clear arriving in the same cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         thr      <= '0;
         rx_ovf   <= 1'b0;
         tx_ovf   <= 1'b0;
         rx_udf   <= 1'b0;
         data_reg <= '0;
      end else begin
         if (ctrl_wr) thr <= data_out_cpu[15:8];
         rx_ovf <= (rx_ovf && !flag_clr) || rx_ovf_evt;
         tx_ovf <= (tx_ovf && !flag_clr) || tx_ovf_evt;
         rx_udf <= (rx_udf && !flag_clr) || rx_udf_evt;
         if (rx_pop) data_reg <= rx_head[DATA_W-1:0];
      end
   end

   assign status = {8'h00, 8'(tx_count), 8'(rx_count), 1'b0, rx_udf, tx_ovf,
                    rx_ovf, tx_full, tx_empty, rx_full, rx_empty};
   assign ctrl_val = {16'h0000, thr, 8'h00};

   always_comb begin
      data_in_cpu = '0;
      if (read_en_cpu) begin
         if (addr_cpu == DATA_W'(0)) begin
            if (!rx_empty) data_in_cpu = rx_head[FW-1:DATA_W];
         end else if (addr_cpu == DATA_W'(1)) begin
            data_in_cpu = data_reg;
         end else if (addr_cpu == DATA_W'(2)) begin
            data_in_cpu = DATA_W'(status);
         end else if (is_ctrl) begin
            data_in_cpu = DATA_W'(ctrl_val);
         end
      end
   end
endmodule

// File: tb/tb_noc_interface.sv
// tb/tb_noc_interface.sv - scoreboard bench for noc_interface

module tb_noc_interface;
   localparam int          DEPTH = 16;
   localparam logic [31:0] CTRL  = 32'hFFFF_FFFC;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] addr_cpu, data_out_cpu, data_in_cpu;
   logic        read_en_cpu, write_en_cpu;
   logic        tx_valid, tx_ready, rx_valid, rx_ready, irq;
   logic [63:0] tx_data, rx_data;

   noc_interface dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .addr_cpu     (addr_cpu),
      .data_out_cpu (data_out_cpu),
      .data_in_cpu  (data_in_cpu),
      .read_en_cpu  (read_en_cpu),
      .write_en_cpu (write_en_cpu),
      .tx_valid     (tx_valid),
      .tx_data      (tx_data),
      .tx_ready     (tx_ready),
      .rx_valid     (rx_valid),
      .rx_data      (rx_data),
      .rx_ready     (rx_ready),
      .irq          (irq)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        txv;
      logic        rxr;
      logic        irq;
      logic [63:0] txd;
   } sig_t;

   sig_t        exp_sig[$];
   logic [31:0] exp_rd[$];
   logic [63:0] exp_tx[$];

   // Reference model state
   logic [63:0] m_tx[$];
   logic [63:0] m_rx[$];
   logic [7:0]  m_thr;
   logic        m_rx_ovf, m_tx_ovf, m_rx_udf;
   logic [31:0] m_dreg;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_tx.delete();
      m_rx.delete();
      m_thr = 8'd0;
      m_rx_ovf = 1'b0;
      m_tx_ovf = 1'b0;
      m_rx_udf = 1'b0;
      m_dreg = 32'd0;
   endtask

   function automatic logic [31:0] model_read(input logic [31:0] a);
      logic [31:0] st;
      st = 32'd0;
      st[0] = (m_rx.size() == 0);
      st[1] = (m_rx.size() == DEPTH);
      st[2] = (m_tx.size() == 0);
      st[3] = (m_tx.size() == DEPTH);
      st[4] = m_rx_ovf;
      st[5] = m_tx_ovf;
      st[6] = m_rx_udf;
      st[15:8]  = 8'(m_rx.size());
      st[23:16] = 8'(m_tx.size());
      if (a == 32'd0)      return (m_rx.size() == 0) ? 32'd0 : m_rx[0][63:32];
      else if (a == 32'd1) return m_dreg;
      else if (a == 32'd2) return st;
      else if (a == CTRL)  return {16'd0, m_thr, 8'd0};
      else                 return 32'd0;
   endfunction

   // One clock cycle: drive inputs, queue what the DUT must show this cycle,
   // then advance the model to its state after the edge.
   task automatic cyc(input logic we, input logic re, input logic [31:0] a,
                      input logic [31:0] wd, input logic rv, input logic [63:0] rd,
                      input logic tr);
      sig_t s;
      bit   tx_full_pre, rx_full_pre, rx_empty_pre, tx_pop, rx_pop;
      write_en_cpu = we; read_en_cpu = re; addr_cpu = a; data_out_cpu = wd;
      rx_valid = rv; rx_data = rd; tx_ready = tr;

      s.txv = (m_tx.size() != 0);
      s.txd = s.txv ? m_tx[0] : 64'd0;
      s.rxr = (m_rx.size() != DEPTH);
      s.irq = (m_thr != 0) && (m_rx.size() >= int'(m_thr));
      exp_sig.push_back(s);
      if (re) exp_rd.push_back(model_read(a));
      if (tr && m_tx.size() != 0) exp_tx.push_back(m_tx[0]);

      tx_full_pre  = (m_tx.size() == DEPTH);
      rx_full_pre  = (m_rx.size() == DEPTH);
      rx_empty_pre = (m_rx.size() == 0);
      tx_pop = tr && (m_tx.size() != 0);
      rx_pop = re && (a == 32'd0) && !rx_empty_pre;
      if (rx_pop) begin
         m_dreg = m_rx[0][31:0];
         void'(m_rx.pop_front());
      end
      if (tx_pop) void'(m_tx.pop_front());
      if (we && a == CTRL) begin
         m_thr = wd[15:8];
         if (wd[0]) begin
            m_rx_ovf = 1'b0; m_tx_ovf = 1'b0; m_rx_udf = 1'b0;
         end
      end
      if (we && a != CTRL) begin
         if (tx_full_pre && !tx_pop) m_tx_ovf = 1'b1;
         else m_tx.push_back({a, wd});
      end
      if (rv) begin
         if (rx_full_pre) m_rx_ovf = 1'b1;
         else m_rx.push_back(rd);
      end
      if (re && a == 32'd0 && rx_empty_pre) m_rx_udf = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic idle();                               cyc(0, 0, 0, 0, 0, 0, 0); endtask
   task automatic do_wr(input logic [31:0] a, input logic [31:0] d); cyc(1, 0, a, d, 0, 0, 0); endtask
   task automatic do_rd(input logic [31:0] a);          cyc(0, 1, a, 0, 0, 0, 0); endtask
   task automatic do_rx(input logic [63:0] f);          cyc(0, 0, 0, 0, 1, f, 0); endtask
   task automatic do_pop();                             cyc(0, 0, 0, 0, 0, 0, 1); endtask

   // Reset with handshakes pending; none of them may complete.
   task automatic reset_pulse();
      rst_n = 1'b0;
      write_en_cpu = 1'b1; addr_cpu = 32'd9; data_out_cpu = 32'h55;
      read_en_cpu = 1'b0; rx_valid = 1'b1; rx_data = 64'h1; tx_ready = 1'b1;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      write_en_cpu = 1'b0; rx_valid = 1'b0; tx_ready = 1'b0;
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (exp_sig.size() == 0) begin
            chk("sig_missing", 64'd1, 64'd0);
         end else begin
            sig_t s;
            s = exp_sig.pop_front();
            chk("tx_valid", {63'd0, tx_valid}, {63'd0, s.txv});
            chk("tx_data",  tx_data, s.txd);
            chk("rx_ready", {63'd0, rx_ready}, {63'd0, s.rxr});
            chk("irq",      {63'd0, irq}, {63'd0, s.irq});
         end
         if (read_en_cpu) begin
            if (exp_rd.size() == 0) chk("read_unexpected", 64'd1, 64'd0);
            else chk("cpu_read", {32'd0, data_in_cpu}, {32'd0, exp_rd.pop_front()});
         end else begin
            chk("read_idle_zero", {32'd0, data_in_cpu}, 64'd0);
         end
         if (tx_valid && tx_ready) begin
            if (exp_tx.size() == 0) chk("tx_unexpected", tx_data, 64'd0);
            else chk("tx_flit", tx_data, exp_tx.pop_front());
         end
      end
   end

   initial begin
      rst_n = 1'b0;
      write_en_cpu = 0; read_en_cpu = 0; addr_cpu = 0; data_out_cpu = 0;
      rx_valid = 0; rx_data = 0; tx_ready = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Reset values
      idle();
      do_rd(32'd2);

      // TX loopback
      do_wr(32'd5, 32'hAB);
      idle();
      do_pop();
      do_rd(32'd2);

      // RX pop sequence
      do_rx({32'd7, 32'h1234});
      do_rd(32'd0);
      do_rd(32'd1);
      do_rd(32'd2);

      // TX overflow, sticky clear, drain
      for (int i = 0; i < 17; i++) do_wr(32'd100 + i, $urandom);
      do_rd(32'd2);
      do_wr(CTRL, 32'h1);
      do_rd(32'd2);
      repeat (17) do_pop();

      // Full TX push coinciding with a pop
      for (int i = 0; i < 16; i++) do_wr(32'd200 + i, $urandom);
      cyc(1, 0, 32'd300, 32'hC0FFEE, 0, 0, 1);
      do_rd(32'd2);
      repeat (16) do_pop();
      do_rd(32'd2);

      // RX full, overflow, drain, wrapped refill, underflow
      for (int i = 0; i < 16; i++) do_rx({32'(i + 1), $urandom});
      idle();
      do_rx({32'd99, 32'hDEAD});
      do_rd(32'd2);
      repeat (16) do_rd(32'd0);
      for (int i = 0; i < 16; i++) do_rx({$urandom, $urandom});
      repeat (16) do_rd(32'd0);
      do_rd(32'd0);
      do_rd(32'd2);
      do_wr(CTRL, 32'h1);

      // Interrupt threshold
      do_wr(CTRL, 32'h0000_0300);
      do_rd(CTRL);
      do_rx({32'd1, 32'd11});
      do_rx({32'd2, 32'd22});
      idle();
      do_rx({32'd3, 32'd33});
      idle();
      do_rd(32'd0);
      idle();
      do_wr(32'd8, 32'd88);
      reset_pulse();
      do_rd(32'd2);
      do_rd(CTRL);

      // Randomised traffic in phases with different pressure
      for (int ph = 0; ph < 4; ph++) begin
         for (int n = 0; n < 500; n++) begin
            logic        we, re, rv, tr;
            logic [31:0] a, wd;
            int          pick;
            we = ($urandom_range(0, 2) == 0);
            re = ($urandom_range(0, 2) == 0);
            rv = ($urandom_range(0, 3) < ((ph == 1) ? 3 : 2));
            tr = ($urandom_range(0, 3) < ((ph == 0) ? 1 : (ph == 2) ? 3 : 2));
            pick = $urandom_range(0, 7);
            case (pick)
               0, 1:    a = 32'd0;
               2:       a = 32'd1;
               3:       a = 32'd2;
               4:       a = CTRL;
               default: a = $urandom_range(3, 1000);
            endcase
            wd = $urandom;
            if (a == CTRL) wd = {16'd0, 8'($urandom_range(0, 18)), 7'd0, wd[0]};
            if ($urandom_range(0, 299) == 0) reset_pulse();
            cyc(we, re, a, wd, rv, {$urandom, $urandom}, tr);
         end
      end

      idle();
      chk("tx_scoreboard_left", 64'(exp_tx.size()), 64'd0);
      chk("rd_scoreboard_left", 64'(exp_rd.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
